// File: rtl/osd_regaccess_arb_pkg.sv
// Shared register-access constants and the arbiter state encoding.
package osd_regaccess_pkg;
    localparam int unsigned REG_ADDR_W = 16;
    localparam int unsigned REG_DATA_W = 16;
    localparam int unsigned REG_SIZE_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } regaccess_state_t;
endpackage

// File: rtl/osd_regaccess_arb_if.sv
// Requester-side and decode-side signals of the shared register-access port.
interface osd_regaccess_arb_if #(
    parameter int unsigned NUM_REQ = 2
);
    import osd_regaccess_pkg::*;

    logic [NUM_REQ-1:0]            req_request;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*REG_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*REG_SIZE_W-1:0] req_size;
    logic [NUM_REQ*REG_DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ack;
    logic                          req_err;
    logic [REG_DATA_W-1:0]         req_rdata;

    logic                          tgt_request;
    logic                          tgt_write;
    logic [REG_ADDR_W-1:0]         tgt_addr;
    logic [REG_SIZE_W-1:0]         tgt_size;
    logic [REG_DATA_W-1:0]         tgt_wdata;
    logic                          tgt_ack;
    logic                          tgt_err;
    logic [REG_DATA_W-1:0]         tgt_rdata;

    // Arbiter side.
    modport slave (
        input  req_request, req_write, req_addr, req_size, req_wdata,
        output req_ack, req_err, req_rdata,
        output tgt_request, tgt_write, tgt_addr, tgt_size, tgt_wdata,
        input  tgt_ack, tgt_err, tgt_rdata
    );

    // Requesters plus register decode.
    modport master (
        output req_request, req_write, req_addr, req_size, req_wdata,
        input  req_ack, req_err, req_rdata,
        input  tgt_request, tgt_write, tgt_addr, tgt_size, tgt_wdata,
        output tgt_ack, tgt_err, tgt_rdata
    );
endinterface

// File: rtl/osd_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping at N.
module osd_rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);
    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] c;

    always_comb begin
        valid = 1'b0;
        grant = '0;
        idx   = '0;
        cand  = '0;
        c     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            c = cand[IDX_W-1:0];
            if (!valid && req[c]) begin
                valid    = 1'b1;
                grant[c] = 1'b1;
                idx      = c;
            end
        end
    end
endmodule

// File: rtl/osd_regaccess_arb.sv
// Round-robin share of one register-access port among NUM_REQ requesters, with a
// watchdog that turns a silent register decode into an error response.
module osd_regaccess_arb
    import osd_regaccess_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    osd_regaccess_arb_if.slave bus,
    output logic               busy
);
    localparam int unsigned     IDX_W   = $clog2(NUM_REQ);
    localparam int unsigned     WD_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit              WD_EN   = (TIMEOUT != 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    regaccess_state_t      state_q, state_d;
    logic [IDX_W-1:0]      ptr_q;
    logic                  gnt_valid;
    logic [NUM_REQ-1:0]    gnt_onehot;
    logic [IDX_W-1:0]      gnt_idx;
    logic [NUM_REQ-1:0]    owner_q;
    logic [WD_W-1:0]       wdog_q;
    logic                  expire;
    logic                  rsp_err_q;
    logic [REG_DATA_W-1:0] rsp_rdata_q;
    logic                  write_q, sel_write;
    logic [REG_ADDR_W-1:0] addr_q, sel_addr;
    logic [REG_SIZE_W-1:0] size_q, sel_size;
    logic [REG_DATA_W-1:0] wdata_q, sel_wdata;

    osd_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (bus.req_request),
        .ptr   (ptr_q),
        .valid (gnt_valid),
        .grant (gnt_onehot),
        .idx   (gnt_idx)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_size  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_write = bus.req_write[i];
                sel_addr  = bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                sel_size  = bus.req_size[i*REG_SIZE_W +: REG_SIZE_W];
                sel_wdata = bus.req_wdata[i*REG_DATA_W +: REG_DATA_W];
            end
        end
    end

    assign expire = WD_EN && (wdog_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.tgt_request = 1'b0;
        bus.req_ack     = '0;
        bus.req_err     = 1'b0;
        bus.req_rdata   = '0;
        busy            = (state_q != IDLE);
        case (state_q)
            IDLE:   if (gnt_valid) state_d = ACCESS;
            ACCESS: begin
                bus.tgt_request = 1'b1;
                if (bus.tgt_ack || expire) state_d = DONE;
            end
            DONE: begin
                bus.req_ack   = owner_q;
                bus.req_err   = rsp_err_q;
                bus.req_rdata = rsp_rdata_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A real ack takes priority over watchdog expiry in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q       <= '0;
            owner_q     <= '0;
            wdog_q      <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (gnt_valid) begin
                    ptr_q   <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    owner_q <= gnt_onehot;
                    wdog_q  <= '0;
                    write_q <= sel_write;
                    addr_q  <= sel_addr;
                    size_q  <= sel_size;
                    wdata_q <= sel_wdata;
                end
                ACCESS: begin
                    if (wdog_q != '1) wdog_q <= wdog_q + 1'b1;
                    if (bus.tgt_ack) begin
                        rsp_err_q   <= bus.tgt_err;
                        rsp_rdata_q <= bus.tgt_rdata;
                    end else if (expire) begin
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.tgt_write = write_q;
    assign bus.tgt_addr  = addr_q;
    assign bus.tgt_size  = size_q;
    assign bus.tgt_wdata = wdata_q;
endmodule

// File: tb/tb_osd_regaccess_arb.sv
// Directed plus randomized checks of osd_regaccess_arb against a transaction-level model.
module tb_osd_regaccess_arb;
    localparam int NUM_REQ = 2;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    osd_regaccess_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

    osd_regaccess_arb #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register decode stub: acks ack_delay cycles after tgt_request rises (-1 = never).
    int          ack_delay = -1;
    int          acc_cnt = 0;
    logic        force_ack = 1'b0;
    logic        rsp_err = 1'b0;
    logic [15:0] rsp_rdata = '0;

    always @(posedge clk) acc_cnt <= bus.tgt_request ? acc_cnt + 1 : 0;
    assign bus.tgt_ack   = force_ack | (bus.tgt_request && (ack_delay >= 0) && (acc_cnt == ack_delay));
    assign bus.tgt_err   = rsp_err;
    assign bus.tgt_rdata = rsp_rdata;

    // Requester stimulus and model state.
    logic [NUM_REQ-1:0] cur_req;
    logic               m_write [NUM_REQ];
    logic [15:0]        m_addr  [NUM_REQ];
    logic [1:0]         m_size  [NUM_REQ];
    logic [15:0]        m_wdata [NUM_REQ];
    int                 mptr = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        bus.req_request = cur_req;
        bus.req_write   = {m_write[1], m_write[0]};
        bus.req_addr    = {m_addr[1], m_addr[0]};
        bus.req_size    = {m_size[1], m_size[0]};
        bus.req_wdata   = {m_wdata[1], m_wdata[0]};
    endtask

    task automatic randomize_fields();
        for (int r = 0; r < NUM_REQ; r++) begin
            m_write[r] = 1'($urandom);
            m_addr[r]  = 16'($urandom);
            m_size[r]  = 2'($urandom);
            m_wdata[r] = 16'($urandom);
        end
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
        for (int k = 0; k < NUM_REQ; k++)
            if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic chk_reset(input string pfx);
        chk({pfx, "_busy"},    busy, 0);
        chk({pfx, "_treq"},    bus.tgt_request, 0);
        chk({pfx, "_twrite"},  bus.tgt_write, 0);
        chk({pfx, "_taddr"},   bus.tgt_addr, 0);
        chk({pfx, "_tsize"},   bus.tgt_size, 0);
        chk({pfx, "_twdata"},  bus.tgt_wdata, 0);
        chk({pfx, "_ack"},     bus.req_ack, 0);
        chk({pfx, "_err"},     bus.req_err, 0);
        chk({pfx, "_rdata"},   bus.req_rdata, 0);
    endtask

    // Called in an IDLE cycle with requests already driven; returns in the following IDLE cycle.
    task automatic run_access(input int delay, input bit withdraw, input bit late_ack,
                              output logic [NUM_REQ-1:0] ack_seen, output int ack_cyc);
        int                 g, len;
        bit                 acked;
        logic               exp_err;
        logic [15:0]        exp_rdata;
        logic [NUM_REQ-1:0] exp_ack;
        g         = pick(cur_req, mptr);
        acked     = (delay >= 0) && (delay < TIMEOUT);
        len       = acked ? delay + 1 : TIMEOUT;
        exp_err   = acked ? rsp_err : 1'b1;
        exp_rdata = acked ? rsp_rdata : 16'h0;
        exp_ack   = '0;
        exp_ack[g] = 1'b1;
        ack_delay = delay;
        tick();
        chk("grant_busy",  busy, 1);
        chk("treq_rise",   bus.tgt_request, 1);
        chk("tgt_write",   bus.tgt_write, m_write[g]);
        chk("tgt_addr",    bus.tgt_addr, m_addr[g]);
        chk("tgt_size",    bus.tgt_size, m_size[g]);
        chk("tgt_wdata",   bus.tgt_wdata, m_wdata[g]);
        chk("ack_in_acc",  bus.req_ack, 0);
        if (withdraw) begin
            cur_req = '0;
            drive_reqs();
        end
        for (int c = 1; c < len; c++) begin
            tick();
            chk("treq_hold",  bus.tgt_request, 1);
            chk("taddr_hold", bus.tgt_addr, m_addr[g]);
            chk("ack_early",  bus.req_ack, 0);
        end
        tick();
        ack_seen = bus.req_ack;
        ack_cyc  = cyc;
        chk("treq_fall",  bus.tgt_request, 0);
        chk("req_ack",    bus.req_ack, exp_ack);
        chk("req_err",    bus.req_err, exp_err);
        chk("req_rdata",  bus.req_rdata, exp_rdata);
        mptr = (g + 1) % NUM_REQ;
        cur_req[g] = 1'b0;
        drive_reqs();
        if (late_ack) force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        chk("idle_busy",  busy, 0);
        chk("idle_ack",   bus.req_ack, 0);
        chk("idle_err",   bus.req_err, 0);
        chk("idle_rdata", bus.req_rdata, 0);
    endtask

    initial begin
        logic [NUM_REQ-1:0] seen;
        int                 ac, prev_ac, dly;
        logic [NUM_REQ-1:0] exp_order;

        rst = 1'b0;
        cur_req = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            m_write[r] = 1'b0; m_addr[r] = '0; m_size[r] = '0; m_wdata[r] = '0;
        end
        drive_reqs();
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b1;
        tick();
        chk("post_reset_idle", busy, 0);

        // Single read, combinational decode.
        m_write[0] = 1'b0; m_addr[0] = 16'h0200; m_size[0] = 2'b01; m_wdata[0] = 16'h0;
        cur_req = 2'b01;
        drive_reqs();
        rsp_err = 1'b0; rsp_rdata = 16'hCAFE;
        run_access(0, 1'b0, 1'b0, seen, ac);

        // Write answered with an error.
        m_write[1] = 1'b1; m_addr[1] = 16'h03FF; m_size[1] = 2'b10; m_wdata[1] = 16'h1234;
        cur_req = 2'b10;
        drive_reqs();
        rsp_err = 1'b1; rsp_rdata = 16'h0;
        run_access(0, 1'b0, 1'b0, seen, ac);
        chk("wr_err_ack", seen, 2'b10);

        // Silent decode: watchdog forces error; a late ack in DONE must be ignored.
        randomize_fields();
        cur_req = 2'b01;
        drive_reqs();
        rsp_err = 1'b0; rsp_rdata = 16'hBEEF;
        run_access(-1, 1'b0, 1'b1, seen, ac);

        // Ack lands on the expiry cycle and wins.
        randomize_fields();
        cur_req = 2'b11;
        drive_reqs();
        rsp_err = 1'b0; rsp_rdata = 16'h5A5A;
        run_access(TIMEOUT - 1, 1'b0, 1'b0, seen, ac);

        // Reset during ACCESS aborts the access.
        randomize_fields();
        cur_req = 2'b10;
        drive_reqs();
        ack_delay = -1;
        tick();
        chk("rst_acc_treq", bus.tgt_request, 1);
        rst = 1'b0;
        tick();
        chk_reset("rst_acc");
        rst = 1'b1;
        cur_req = '0;
        drive_reqs();
        mptr = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_no_ack", bus.req_ack, 0);
        end

        // Contention: grant order 0,1,0,1, one ack every 3 cycles.
        randomize_fields();
        cur_req = 2'b11;
        drive_reqs();
        prev_ac = 0;
        for (int i = 0; i < 4; i++) begin
            rsp_err = 1'($urandom); rsp_rdata = 16'($urandom);
            run_access(0, 1'b0, 1'b0, seen, ac);
            exp_order = (i % 2 == 0) ? 2'b01 : 2'b10;
            chk("cont_order", seen, exp_order);
            if (i > 0) chk("cont_spacing", ac - prev_ac, 3);
            prev_ac = ac;
            cur_req = 2'b11;
            drive_reqs();
        end
        cur_req = '0;
        drive_reqs();
        tick();

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            randomize_fields();
            cur_req = NUM_REQ'($urandom_range(0, 3));
            drive_reqs();
            rsp_err = 1'($urandom); rsp_rdata = 16'($urandom);
            if (cur_req == '0) begin
                ack_delay = -1;
                tick();
                chk("rand_idle_busy", busy, 0);
                chk("rand_idle_treq", bus.tgt_request, 0);
            end else begin
                dly = int'($urandom_range(0, 5));
                if (dly == 5) dly = -1;
                run_access(dly, $urandom_range(0, 3) == 0, 1'($urandom), seen, ac);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
